odd_parity_checker: RTL and testbench
=====================================

Name: odd_parity_checker

Overview:
Checks a data word plus its transmitted parity bit against odd parity. An error is flagged when the total number of 1s across data and parity is even. Sits on the receive side of a serial/parallel link, after word capture. It provides a registered per-word error strobe plus sticky and counted error status for CSR readout.

Parameters:
DATA_W, 3, data bits checked per word (excluding the parity bit); legal range 1..64.
CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  data/par qualify this cycle.
data  input  DATA_W  received data bits (bit DATA_W-1 = first bit, "a").
par  input  1  received parity bit ("P").
err_clr  input  1  clears sticky flag and error counter.
out_valid  output  1  registered copy of in_valid.
pec  output  1  parity error check: 1 = odd-parity violation on the word accepted last cycle.
err_sticky  output  1  set by any error since the last reset or clear.
err_cnt  output  CNT_W  number of errored words, saturating.

Behaviour:
- Parity function: pec_next = ~(XOR of all data bits XOR par). An even count of 1s gives 1 (error); an odd count gives 0.
- Latency: 1 cycle. On edge k with in_valid=1: out_valid=1 and pec=pec_next at the output after edge k.
- With in_valid=0: out_valid=0 and pec=0. pec is never asserted without out_valid.
- Reset (rst=1 at the edge): out_valid=0, pec=0, err_sticky=0, err_cnt=0. Reset overrides all other inputs, including mid-stream words, which are dropped.
- err_sticky: set on an edge where in_valid=1 and pec_next=1; holds until rst or err_clr.
- err_cnt: increments by 1 per errored valid word. It saturates at 2^CNT_W-1 with no wrap.
- err_clr alone: err_sticky=0 and err_cnt=0 on that edge.
- err_clr together with an errored valid word in the same cycle: the new error wins. Result is err_sticky=1 and err_cnt=1.
- err_clr does not affect out_valid or pec.
- Inputs are sampled only when in_valid=1. data and par may be X when in_valid=0 without corrupting state.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package odd_parity_pkg holds DATA_W_DEF=3, CNT_W_DEF=8, and the function count_max(CNT_W) giving the saturation value.
- One sub-module, parity_reduce: a parameterized XOR reduction tree over DATA_W+1 bits, purely combinational, output odd_ones.
- The top level holds the output register stage, sticky flag and saturating counter.

Test Plan:
- Exhaustive sweep, DATA_W=3: all 16 {data,par} combinations with in_valid=1 on consecutive cycles. Expected: data=000,par=0 -> pec=1; 000,1 -> 0; 001,0 -> 0; 011,0 -> 1; 111,0 -> 0; 111,1 -> 1. pec lags the input by exactly one cycle, out_valid is high throughout, final err_cnt=8, err_sticky=1.
- Bubbles: alternate in_valid 1/0 with data=000,par=0. Expected: pec/out_valid toggle 1,0,1,0 and err_cnt increments only on valid cycles.
- Saturation with CNT_W=2: six errored words. Expected: err_cnt reads 1,2,3,3,3,3.
- Clear collision: err_cnt=5; assert err_clr with a clean word (data=001,par=0). Expected: err_cnt=0, err_sticky=0. Then repeat err_clr with an errored word (000,0). Expected: err_cnt=1, err_sticky=1.
- Reset mid-stream: assert rst during a valid errored word. Expected: next cycle all outputs 0 and the word is not counted. The stream resumes correctly on the cycle after rst deasserts.
- Width check, DATA_W=8: data=8'hFF,par=0 -> pec=1; data=8'hFE,par=0 -> pec=0.

Source files
------------

// File: rtl/odd_parity_pkg.sv
// Shared definitions for the odd-parity checker: default widths and the
// saturation value of the error counter.
package odd_parity_pkg;

  localparam int unsigned DATA_W_DEF = 3;
  localparam int unsigned CNT_W_DEF  = 8;

  // Largest value representable in cnt_w bits (2^cnt_w - 1), cnt_w in 1..64.
  function automatic logic [63:0] count_max(input int unsigned cnt_w);
    return (64'(1) << cnt_w) - 64'(1);
  endfunction

endpackage : odd_parity_pkg

// File: rtl/odd_parity_checker_if.sv
// Receive-side word/status bundle for the odd-parity checker.
// master: word source and CSR reader (drives in_valid/data/par/err_clr).
// slave : the checker (drives out_valid/pec/err_sticky/err_cnt).
interface odd_parity_checker_if
  import odd_parity_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic              in_valid;
  logic [DATA_W-1:0] data;
  logic              par;
  logic              err_clr;
  logic              out_valid;
  logic              pec;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output in_valid, data, par, err_clr,
    input  out_valid, pec, err_sticky, err_cnt
  );

  modport slave (
    input  in_valid, data, par, err_clr,
    output out_valid, pec, err_sticky, err_cnt
  );

endinterface : odd_parity_checker_if

// File: rtl/odd_parity_checker_parity_reduce.sv
// Purely combinational XOR reduction over N bits.
// Ports: bits (N) in; odd_ones out, 1 when bits holds an odd number of 1s.
module parity_reduce #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] bits,
  output logic         odd_ones
);

  // Reduction XOR maps onto a balanced tree in synthesis.
  assign odd_ones = ^bits;

endmodule : parity_reduce

// File: rtl/odd_parity_checker.sv
// Odd-parity checker: registers a per-word error strobe one cycle after an
// accepted word and keeps sticky and saturating-count error status.
// Ports: clk, rst (sync, active-high); bus (slave modport) carrying
//   in_valid/data/par/err_clr in and out_valid/pec/err_sticky/err_cnt out.
module odd_parity_checker
  import odd_parity_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  odd_parity_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(count_max(CNT_W));

  logic             w_odd_ones;
  logic             w_err;
  logic             r_out_valid;
  logic             r_pec;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_err_cnt;

  parity_reduce #(
    .N (DATA_W + 1)
  ) u_parity_reduce (
    .bits     ({bus.data, bus.par}),
    .odd_ones (w_odd_ones)
  );

  // in_valid gates first so X data on idle cycles cannot reach state.
  assign w_err = bus.in_valid & ~w_odd_ones;

  // Output stage and status; a new error outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_pec        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_out_valid <= bus.in_valid;
      r_pec       <= w_err;
      if (w_err) begin
        r_err_sticky <= 1'b1;
        if (bus.err_clr) begin
          r_err_cnt <= CNT_W'(1);
        end else if (r_err_cnt != CNT_MAX) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
      end else if (bus.err_clr) begin
        r_err_sticky <= 1'b0;
        r_err_cnt    <= '0;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.pec        = r_pec;
  assign bus.err_sticky = r_err_sticky;
  assign bus.err_cnt    = r_err_cnt;

endmodule : odd_parity_checker

// File: tb/tb_odd_parity_checker.sv
// Bench for odd_parity_checker: three instances (3/8, 3/2, 8/8 data/count
// widths) driven in lockstep, checked against a scoreboard of expectations.
module tb_odd_parity_checker;

  typedef struct packed {
    logic [2:0]  ov;
    logic [2:0]  pec;
    logic [2:0]  st;
    logic [23:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  exp_t sb[$];
  int   m_st  [3];
  int   m_cnt [3];
  int   m_max [3];

  odd_parity_checker_if #(.DATA_W(3), .CNT_W(8)) if_a ();
  odd_parity_checker_if #(.DATA_W(3), .CNT_W(2)) if_b ();
  odd_parity_checker_if #(.DATA_W(8), .CNT_W(8)) if_c ();

  odd_parity_checker #(.DATA_W(3), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  odd_parity_checker #(.DATA_W(3), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  odd_parity_checker #(.DATA_W(8), .CNT_W(8)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    assert (act === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] obs(input int k, input int f);
    logic [7:0] v;
    v = 8'h00;
    case (k)
      0: case (f) 0: v = {7'b0, if_a.out_valid}; 1: v = {7'b0, if_a.pec};
                  2: v = {7'b0, if_a.err_sticky}; default: v = if_a.err_cnt; endcase
      1: case (f) 0: v = {7'b0, if_b.out_valid}; 1: v = {7'b0, if_b.pec};
                  2: v = {7'b0, if_b.err_sticky}; default: v = {6'b0, if_b.err_cnt}; endcase
      default: case (f) 0: v = {7'b0, if_c.out_valid}; 1: v = {7'b0, if_c.pec};
                  2: v = {7'b0, if_c.err_sticky}; default: v = if_c.err_cnt; endcase
    endcase
    return v;
  endfunction

  // One cycle: drive at negedge, record expectation, compare after posedge.
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic p, input logic clr, input logic r);
    exp_t       e;
    logic [7:0] dd;
    logic       err;
    int         ones;
    @(negedge clk);
    rst = r;
    if_a.in_valid = v; if_a.data = d[2:0]; if_a.par = p; if_a.err_clr = clr;
    if_b.in_valid = v; if_b.data = d[2:0]; if_b.par = p; if_b.err_clr = clr;
    if_c.in_valid = v; if_c.data = d;      if_c.par = p; if_c.err_clr = clr;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      err = 1'b0;
      if (r) begin
        m_st[k] = 0; m_cnt[k] = 0;
      end else begin
        if (v) begin
          dd   = (k == 2) ? d : {5'b0, d[2:0]};
          ones = $countones(dd) + (p ? 1 : 0);
          err  = ((ones % 2) == 0);
        end
        if (err) begin
          m_st[k]  = 1;
          m_cnt[k] = clr ? 1 : ((m_cnt[k] < m_max[k]) ? m_cnt[k] + 1 : m_cnt[k]);
        end else if (clr) begin
          m_st[k] = 0; m_cnt[k] = 0;
        end
      end
      e.ov[k]          = r ? 1'b0 : v;
      e.pec[k]         = err;
      e.st[k]          = m_st[k][0];
      e.cnt[k*8 +: 8]  = 8'(m_cnt[k]);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s[%0d].out_valid", tag, k), obs(k, 0), {7'b0, e.ov[k]});
      chk($sformatf("%s[%0d].pec", tag, k),       obs(k, 1), {7'b0, e.pec[k]});
      chk($sformatf("%s[%0d].err_sticky", tag, k), obs(k, 2), {7'b0, e.st[k]});
      chk($sformatf("%s[%0d].err_cnt", tag, k),   obs(k, 3), e.cnt[k*8 +: 8]);
    end
  endtask

  initial begin
    logic [3:0] dp;
    n_checks = 0; n_fails = 0;
    m_max[0] = 255; m_max[1] = 3; m_max[2] = 255;
    m_st = '{0, 0, 0}; m_cnt = '{0, 0, 0};
    rst = 1'b1;
    if_a.in_valid = 0; if_a.data = '0; if_a.par = 0; if_a.err_clr = 0;
    if_b.in_valid = 0; if_b.data = '0; if_b.par = 0; if_b.err_clr = 0;
    if_c.in_valid = 0; if_c.data = '0; if_c.par = 0; if_c.err_clr = 0;

    step("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("reset", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);

    // Exhaustive {data,par} sweep, back-to-back.
    for (int i = 0; i < 16; i++) begin
      dp = 4'(i);
      step("sweep", 1'b1, {5'b0, dp[3:1]}, dp[0], 1'b0, 1'b0);
    end
    chk("sweep_final_cnt", if_a.err_cnt, 8'd8);
    chk("sweep_final_sticky", {7'b0, if_a.err_sticky}, 8'd1);

    // Bubbles with X on data/par while idle.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) step("bubble", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      else            step("bubble", 1'b0, 8'hxx, 1'bx, 1'b0, 1'b0);
    end
    chk("bubble_cnt", if_a.err_cnt, 8'd10);

    // Clear alone, then saturation (2-bit counter on instance 1).
    step("clr_alone", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step("saturate", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("saturate_cnt_b", {6'b0, if_b.err_cnt}, 8'd3);
    chk("saturate_cnt_a", if_a.err_cnt, 8'd6);

    // Clear collision: bring count to 5, clear with clean word, then errored word.
    step("clr_prep", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("clr_prep", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("clr_prep_cnt", if_a.err_cnt, 8'd5);
    step("clr_clean", 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("clr_clean_cnt", if_a.err_cnt, 8'd0);
    step("clr_err", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clr_err_cnt", if_a.err_cnt, 8'd1);
    chk("clr_err_sticky", {7'b0, if_a.err_sticky}, 8'd1);

    // Reset mid-stream drops the word; stream resumes afterwards.
    step("pre_rst", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step("mid_rst", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_cnt", if_a.err_cnt, 8'd0);
    step("post_rst", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("post_rst_cnt", if_a.err_cnt, 8'd1);
    step("post_rst", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);

    // Wide words on the 8-bit instance.
    step("wide_ff", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("wide_ff_pec", {7'b0, if_c.pec}, 8'd1);
    step("wide_fe", 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    chk("wide_fe_pec", {7'b0, if_c.pec}, 8'd0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 40; i++) begin
      step("random", 1'($urandom_range(1, 0)), 8'($urandom), 1'($urandom_range(1, 0)),
           ($urandom_range(9, 0) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_odd_parity_checker
